// File: rtl/shift_pkg.sv
//==============================================================================
// Module      : shift_pkg
// Description : Shared shift-type encodings and output-stage state type.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package shift_pkg;

    localparam logic [2:0] SHIFT_LL = 3'b000;
    localparam logic [2:0] SHIFT_LR = 3'b001;
    localparam logic [2:0] SHIFT_AR = 3'b010;
    localparam logic [2:0] SHIFT_RL = 3'b011;
    localparam logic [2:0] SHIFT_RR = 3'b100;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

`default_nettype wire

// File: rtl/barrel_shifter.sv
//==============================================================================
// Module      : barrel_shifter
// Description : Combinational shifter: logical/arithmetic shifts and rotates.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [2:0]       i_type,
    output logic [WIDTH-1:0] o_result
);

    logic [2*WIDTH-1:0] w_rol;
    logic [2*WIDTH-1:0] w_ror;

    // Rotates shift a doubled copy so the wrapped bits fall into the kept half
    assign w_rol = {i_data, i_data} << i_amt;
    assign w_ror = {i_data, i_data} >> i_amt;

    always_comb begin
        o_result = i_data;
        case (i_type)
            SHIFT_LL: o_result = i_data << i_amt;
            SHIFT_LR: o_result = i_data >> i_amt;
            SHIFT_AR: o_result = $signed(i_data) >>> i_amt;
            SHIFT_RL: o_result = w_rol[2*WIDTH-1 -: WIDTH];
            SHIFT_RR: o_result = w_ror[WIDTH-1:0];
            default:  o_result = i_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
//==============================================================================
// Module      : shift_arbiter
// Description : Round-robin sharing of one barrel_shifter with a registered
//               single-entry response stage tagged with the requester ID.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int AMT_W   = $clog2(WIDTH),
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ*AMT_W-1:0] req_amt,
    input  logic [NUM_REQ*3-1:0]     req_type,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id
);

    out_state_t         r_state;
    out_state_t         w_state_next;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;
    logic [ID_W-1:0]    w_ptr;
    logic               w_can_accept;
    logic               w_grant_vld;
    logic [ID_W-1:0]    w_grant_idx;
    logic [WIDTH-1:0]   w_sel_data;
    logic [AMT_W-1:0]   w_sel_amt;
    logic [2:0]         w_sel_type;
    logic [WIDTH-1:0]   w_shift_result;
    int                 w_idx;

    assign rsp_valid    = (r_state == OUT_FULL);
    assign rsp_data     = r_rsp_data;
    assign rsp_id       = r_rsp_id;
    assign w_can_accept = !rsp_valid || rsp_ready;

    // Priority search starting at the pointer, wrapping past NUM_REQ-1
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sel_data  = '0;
        w_sel_amt   = '0;
        w_sel_type  = '0;
        w_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(w_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_grant_vld && w_can_accept && !rst && req_valid[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_idx[ID_W-1:0];
                w_sel_data  = req_data[w_idx*WIDTH +: WIDTH];
                w_sel_amt   = req_amt[w_idx*AMT_W +: AMT_W];
                w_sel_type  = req_type[w_idx*3 +: 3];
            end
        end
    end

    assign req_ready = w_grant_vld ? (NUM_REQ'(1) << w_grant_idx) : '0;

    barrel_shifter #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_barrel_shifter (
        .i_data   (w_sel_data),
        .i_amt    (w_sel_amt),
        .i_type   (w_sel_type),
        .o_result (w_shift_result)
    );

    generate
        if (NUM_REQ > 1) begin : g_ptr_reg
            logic [ID_W-1:0] r_ptr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_grant_vld) begin
                    if (w_grant_idx == ID_W'(NUM_REQ - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= w_grant_idx + ID_W'(1);
                    end
                end
            end

            assign w_ptr = r_ptr;
        end else begin : g_ptr_const
            assign w_ptr = '0;
        end
    endgenerate

    // A grant always refills the stage, so drain+grant keeps it FULL
    always_comb begin
        w_state_next = r_state;
        if (w_grant_vld) begin
            w_state_next = OUT_FULL;
        end else if ((r_state == OUT_FULL) && rsp_ready) begin
            w_state_next = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= OUT_EMPTY;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_vld) begin
                r_rsp_data <= w_shift_result;
                r_rsp_id   <= w_grant_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
//==============================================================================
// Module      : tb_shift_arbiter
// Description : Randomized scoreboard bench for shift_arbiter (WIDTH=8, NUM_REQ=4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int AMT_W   = 3;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ*AMT_W-1:0] req_amt;
    logic [NUM_REQ*3-1:0]     req_type;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;

    logic [WIDTH-1:0] d_data [NUM_REQ];
    logic [AMT_W-1:0] d_amt  [NUM_REQ];
    logic [2:0]       d_type [NUM_REQ];

    int checks = 0;
    int errors = 0;

    int p_new = 100;
    int p_rdy = 100;
    int inj_req = 0;
    int inj_ack = 0;
    int inj_idx = 0;
    logic [WIDTH-1:0] inj_data;
    logic [AMT_W-1:0] inj_amt;
    logic [2:0]       inj_type;

    logic [ID_W+WIDTH-1:0] exp_q[$];
    int m_ptr = 0;
    bit m_full = 1'b0;
    bit prev_rst = 1'b0;

    shift_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_type  (req_type),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        req_amt  = '0;
        req_type = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = d_data[i];
            req_amt[i*AMT_W +: AMT_W]  = d_amt[i];
            req_type[i*3 +: 3]         = d_type[i];
        end
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Shift result from arithmetic on the integer value of the operand
    function automatic logic [WIDTH-1:0] ref_shift(input int v, input int a, input int t);
        int p, r, s;
        p = 1 << a;
        case (t)
            0: r = (v * p) % 256;
            1: r = v / p;
            2: begin
                s = (v >= 128) ? v - 256 : v;
                if (s < 0) s = -((-s + p - 1) / p);
                else       s = s / p;
                r = s & 255;
            end
            3: r = (v * p) % 256 + v / (256 / p);
            4: r = v / p + (v % p) * (256 / p);
            default: r = v;
        endcase
        return r[WIDTH-1:0];
    endfunction

    // Requester driver
    initial begin
        logic [NUM_REQ-1:0] cap;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d_data[i] = '0; d_amt[i] = '0; d_type[i] = '0;
        end
        forever begin
            @(negedge clk);
            cap = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && cap[i]) begin
                    if ($urandom_range(0, 99) < p_new) begin
                        d_data[i] = WIDTH'($urandom);
                        d_amt[i]  = AMT_W'($urandom);
                        d_type[i] = 3'($urandom_range(0, 7));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if (!req_valid[i]) begin
                    if (inj_req != inj_ack && inj_idx == i) begin
                        d_data[i] = inj_data;
                        d_amt[i]  = inj_amt;
                        d_type[i] = inj_type;
                        req_valid[i] = 1'b1;
                        inj_ack = inj_req;
                    end else if ($urandom_range(0, 99) < p_new) begin
                        d_data[i] = WIDTH'($urandom);
                        d_amt[i]  = AMT_W'($urandom);
                        d_type[i] = 3'($urandom_range(0, 7));
                        req_valid[i] = 1'b1;
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 99) < p_rdy);
        end
    end

    // Reference model: predicts grants and pushes expected responses
    initial begin
        int g;
        bit can;
        logic [NUM_REQ-1:0] exp_ready;
        forever begin
            @(negedge clk);
            #1;
            if (prev_rst) begin
                check(rsp_valid == 1'b0, "post_reset_valid", 32'(rsp_valid), 0);
                check(rsp_data == '0, "post_reset_data", 32'(rsp_data), 0);
                check(rsp_id == '0, "post_reset_id", 32'(rsp_id), 0);
            end
            if (rst) begin
                check(req_ready == '0, "reset_ready", 32'(req_ready), 0);
                exp_q.delete();
                m_full = 1'b0;
                m_ptr = 0;
                prev_rst = 1'b1;
            end else begin
                prev_rst = 1'b0;
                check(rsp_valid == m_full, "rsp_valid", 32'(rsp_valid), 32'(m_full));
                can = !m_full || rsp_ready;
                g = -1;
                if (can) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
                    end
                end
                exp_ready = (g >= 0) ? NUM_REQ'(1 << g) : '0;
                check(req_ready == exp_ready, "req_ready", 32'(req_ready), 32'(exp_ready));
                if (g >= 0) begin
                    exp_q.push_back({ID_W'(g), ref_shift(int'(d_data[g]), int'(d_amt[g]), int'(d_type[g]))});
                    m_ptr = (g + 1) % NUM_REQ;
                    m_full = 1'b1;
                end else if (m_full && rsp_ready) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    // Response monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "rsp_unexpected", 32'({rsp_id, rsp_data}), 0);
                end else begin
                    check({rsp_id, rsp_data} == exp_q[0], "rsp_id_data",
                          32'({rsp_id, rsp_data}), 32'(exp_q[0]));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Requesters must hold valid and fields until accepted
    initial begin
        logic [NUM_REQ-1:0] pv, pr;
        logic [WIDTH-1:0]   pd [NUM_REQ];
        logic [AMT_W-1:0]   pa [NUM_REQ];
        logic [2:0]         pt [NUM_REQ];
        bit                 have = 1'b0;
        forever begin
            @(negedge clk);
            if (have) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (pv[i] && !pr[i]) begin
                        check(req_valid[i] && d_data[i] == pd[i] && d_amt[i] == pa[i] && d_type[i] == pt[i],
                              "requester_hold", 32'(req_valid[i]), 1);
                    end
                end
            end
            pv = req_valid;
            pr = req_ready;
            for (int i = 0; i < NUM_REQ; i++) begin
                pd[i] = d_data[i]; pa[i] = d_amt[i]; pt[i] = d_type[i];
            end
            have = 1'b1;
        end
    end

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (req_valid == '0 && !rsp_valid) done = 1'b1;
        end
        check(done, "idle_timeout", 32'(done), 1);
    endtask

    task automatic run_vector(input int idx, input logic [7:0] data, input int amt,
                              input logic [2:0] typ, input logic [7:0] exp);
        bit seen;
        inj_idx  = idx;
        inj_data = data;
        inj_amt  = AMT_W'(amt);
        inj_type = typ;
        inj_req++;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check(seen, "vector_rsp_valid", 32'(seen), 1);
        check(rsp_data == exp, "vector_rsp_data", 32'(rsp_data), 32'(exp));
        check(rsp_id == ID_W'(idx), "vector_rsp_id", 32'(rsp_id), 32'(idx));
        wait_idle();
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        p_new = 100;
        p_rdy = 100;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // All requesters continuously valid: round-robin order
        repeat (12) @(posedge clk);

        @(posedge clk); #2;
        p_new = 0;
        wait_idle();
        run_vector(2, 8'h96, 3, SHIFT_RL, 8'hB4);
        run_vector(1, 8'h90, 2, SHIFT_AR, 8'hE4);
        run_vector(3, 8'h90, 2, 3'b111,   8'h90);
        run_vector(0, 8'h81, 0, SHIFT_RR, 8'h81);

        // Backpressure then release
        @(posedge clk); #2;
        p_rdy = 0;
        p_new = 100;
        repeat (6) @(posedge clk);
        #2 p_rdy = 100;
        repeat (8) @(posedge clk);

        // Reset while a result is held
        #2 p_rdy = 0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check(seen, "midop_rsp_valid", 32'(seen), 1);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        p_rdy = 100;
        repeat (10) @(posedge clk);

        // Random traffic
        #2;
        p_new = 40;
        p_rdy = 70;
        repeat (400) @(posedge clk);

        #2;
        p_new = 0;
        p_rdy = 100;
        wait_idle();
        check(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
